// File: rtl/fmm_reduce_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fmm_reduce_pkg : shared types/constants for the pivot row scanner  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fmm_reduce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_e;

    localparam int          DEFAULT_ROW_STRIDE = 320;
    localparam int          DEFAULT_MATCH_VAL  = 1;
    localparam logic [31:0] PIVOT_NONE         = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/fmm_strided_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fmm_strided_addr_gen : row counter plus stride accumulator         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fmm_strided_addr_gen #(
    parameter int ADDR_W     = 17,
    parameter int ROW_STRIDE = 320
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               advance,
    input  logic [ADDR_W-1:0]  base,
    input  logic signed [31:0] limit,
    output logic [30:0]        row,
    output logic [ADDR_W-1:0]  addr,
    output logic               exhausted,
    output logic               last
);

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(ROW_STRIDE);

    logic [30:0]        row_q, row_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic signed [32:0] row_ext;
    logic signed [32:0] limit_ext;

    always_comb begin
        row_d  = row_q;
        addr_d = addr_q;
        if (load) begin
            row_d  = '0;
            addr_d = base;
        end else if (advance) begin
            row_d  = row_q + 31'd1;
            addr_d = addr_q + STRIDE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

    // 33-bit signed compare so row+1 cannot wrap negative
    assign row_ext   = $signed({2'b00, row_q});
    assign limit_ext = $signed({limit[31], limit});
    assign exhausted = row_ext >= limit_ext;
    assign last      = (row_ext + 33'sd1) >= limit_ext;
    assign row       = row_q;
    assign addr      = addr_q;

endmodule
`default_nettype wire

// File: rtl/fmm_reduce_pivot_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fmm_reduce_pivot_scan_ctrl : pipelined first-pivot row scan        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fmm_reduce_pivot_scan_ctrl
    import fmm_reduce_pkg::*;
#(
    parameter int ADDR_W     = 17,
    parameter int ROW_STRIDE = DEFAULT_ROW_STRIDE,
    parameter int DATA_W     = 32,
    parameter int MATCH_VAL  = DEFAULT_MATCH_VAL
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               ap_start,
    output logic               ap_done,
    output logic               ap_idle,
    output logic               ap_ready,
    input  logic signed [31:0] row_count,
    input  logic [ADDR_W-1:0]  col_base,
    input  logic               mem_gnt,
    output logic [ADDR_W-1:0]  M_e_address0,
    output logic               M_e_ce0,
    input  logic [DATA_W-1:0]  M_e_q0,
    output logic [31:0]        pivot_row,
    output logic               pivot_row_ap_vld
);

    scan_state_e        state_q, state_d;
    logic signed [31:0] row_count_q, row_count_d;
    logic               rd_vld_q, rd_vld_d;
    logic [30:0]        rd_row_q, rd_row_d;
    logic [31:0]        pivot_row_q, pivot_row_d;
    logic               ap_done_q, ap_done_d;
    logic               ap_ready_q, ap_ready_d;

    logic               gen_load;
    logic               issue;
    logic               hit;
    logic [30:0]        issue_row;
    logic [ADDR_W-1:0]  issue_addr;
    logic               exhausted;
    logic               last_row;

    fmm_strided_addr_gen #(
        .ADDR_W     (ADDR_W),
        .ROW_STRIDE (ROW_STRIDE)
    ) u_addr_gen (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .load      (gen_load),
        .advance   (issue),
        .base      (col_base),
        .limit     (row_count_q),
        .row       (issue_row),
        .addr      (issue_addr),
        .exhausted (exhausted),
        .last      (last_row)
    );

    assign M_e_ce0      = (state_q == ST_SCAN) && !exhausted;
    assign M_e_address0 = issue_addr;
    assign issue        = M_e_ce0 && mem_gnt;
    assign hit          = rd_vld_q && (M_e_q0 == DATA_W'(MATCH_VAL));

    always_comb begin
        state_d     = state_q;
        row_count_d = row_count_q;
        rd_vld_d    = issue;
        rd_row_d    = issue ? issue_row : rd_row_q;
        pivot_row_d = pivot_row_q;
        ap_done_d   = 1'b0;
        ap_ready_d  = 1'b0;
        gen_load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rd_vld_d = 1'b0;
                if (ap_start) begin
                    ap_ready_d  = 1'b1;
                    row_count_d = row_count;
                    gen_load    = 1'b1;
                    if (row_count <= 32'sd0) begin
                        pivot_row_d = PIVOT_NONE;
                        ap_done_d   = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                // A hit squashes whatever read is being issued alongside it
                if (hit) begin
                    pivot_row_d = {1'b0, rd_row_q};
                    rd_vld_d    = 1'b0;
                    ap_done_d   = 1'b1;
                    state_d     = ST_DONE;
                end else if (issue && last_row) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                rd_vld_d = 1'b0;
                if (rd_vld_q) begin
                    pivot_row_d = hit ? {1'b0, rd_row_q} : PIVOT_NONE;
                    ap_done_d   = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            default: begin
                rd_vld_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q     <= ST_IDLE;
            row_count_q <= '0;
            rd_vld_q    <= 1'b0;
            rd_row_q    <= '0;
            pivot_row_q <= PIVOT_NONE;
            ap_done_q   <= 1'b0;
            ap_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_count_q <= row_count_d;
            rd_vld_q    <= rd_vld_d;
            rd_row_q    <= rd_row_d;
            pivot_row_q <= pivot_row_d;
            ap_done_q   <= ap_done_d;
            ap_ready_q  <= ap_ready_d;
        end
    end

    assign ap_done          = ap_done_q;
    assign ap_ready         = ap_ready_q;
    assign ap_idle          = (state_q == ST_IDLE);
    assign pivot_row        = pivot_row_q;
    assign pivot_row_ap_vld = ap_done_q;

endmodule
`default_nettype wire

// File: tb/tb_fmm_reduce_pivot_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fmm_reduce_pivot_scan_ctrl : directed + random pivot scan bench |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fmm_reduce_pivot_scan_ctrl;

    localparam int ADDR_W = 17;
    localparam int STRIDE = 320;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n = 1'b0;
    logic               ap_start = 1'b0;
    logic               ap_done, ap_idle, ap_ready;
    logic signed [31:0] row_count = '0;
    logic [ADDR_W-1:0]  col_base = '0;
    logic               mem_gnt = 1'b0;
    logic [ADDR_W-1:0]  M_e_address0;
    logic               M_e_ce0;
    logic [31:0]        M_e_q0 = '0;
    logic [31:0]        pivot_row;
    logic               pivot_row_ap_vld;

    int vectors = 0;
    int miscompares = 0;
    int unsigned mem [int];

    fmm_reduce_pivot_scan_ctrl dut (
        .ap_clk           (ap_clk),
        .ap_rst_n         (ap_rst_n),
        .ap_start         (ap_start),
        .ap_done          (ap_done),
        .ap_idle          (ap_idle),
        .ap_ready         (ap_ready),
        .row_count        (row_count),
        .col_base         (col_base),
        .mem_gnt          (mem_gnt),
        .M_e_address0     (M_e_address0),
        .M_e_ce0          (M_e_ce0),
        .M_e_q0           (M_e_q0),
        .pivot_row        (pivot_row),
        .pivot_row_ap_vld (pivot_row_ap_vld)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic logic [31:0] rd_mem(input int a);
        return mem.exists(a) ? mem[a] : 32'd0;
    endfunction

    // Granted reads return data next cycle; otherwise junk that never matches
    always @(posedge ap_clk) begin
        if (M_e_ce0 && mem_gnt) M_e_q0 <= rd_mem(int'(M_e_address0));
        else                    M_e_q0 <= $urandom() | 32'h2;
    end

    function automatic int row_addr(input logic [ADDR_W-1:0] b, input int k);
        return (int'(b) + k * STRIDE) & 32'h1FFFF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    // mode 0: grant always; 1: random grant; 2: grant on even cycles only
    task automatic run_scan(input string tag, input int n, input logic [ADDR_W-1:0] base,
                            input int mode);
        bit                gp [0:511];
        int                t [$];
        logic [ADDR_W-1:0] issued [$];
        int                h, exp_done, exp_issues, done_cyc;
        logic [31:0]       exp_pivot, got_pivot;

        for (int c = 0; c < 512; c++) begin
            case (mode)
                0:       gp[c] = 1'b1;
                1:       gp[c] = ($urandom_range(0, 3) != 0);
                default: gp[c] = ((c % 2) == 0);
            endcase
        end
        for (int c = 1; c < 512; c++) if (gp[c]) t.push_back(c);

        h = -1;
        for (int k = 0; k < n; k++) begin
            if (rd_mem(row_addr(base, k)) == 32'd1) begin
                h = k;
                break;
            end
        end
        exp_pivot  = (h >= 0) ? 32'(h) : 32'hFFFF_FFFF;
        exp_issues = 0;
        if (n <= 0) begin
            exp_done = 1;
        end else begin
            exp_done = (h >= 0) ? t[h] + 2 : t[n-1] + 2;
            for (int k = 0; k < n; k++)
                if (h < 0 || t[k] <= t[h] + 1) exp_issues++;
        end

        chk({tag, "/idle_before"}, {31'd0, ap_idle}, 32'd1);
        row_count = n;
        col_base  = base;
        ap_start  = 1'b1;
        mem_gnt   = 1'b0;
        @(negedge ap_clk);
        ap_start  = 1'b0;
        row_count = $urandom();
        col_base  = ADDR_W'($urandom());
        done_cyc  = -1;
        got_pivot = 'x;
        for (int c = 1; c < 400; c++) begin
            mem_gnt = gp[c];
            if (M_e_ce0 && mem_gnt) issued.push_back(M_e_address0);
            if (c == 1) chk({tag, "/ready"}, {31'd0, ap_ready}, 32'd1);
            if (ap_done) begin
                done_cyc  = c;
                got_pivot = pivot_row;
                chk({tag, "/vld"}, {31'd0, pivot_row_ap_vld}, 32'd1);
                break;
            end
            @(negedge ap_clk);
        end
        mem_gnt = 1'b0;
        chk({tag, "/done_cycle"}, 32'(done_cyc), 32'(exp_done));
        chk({tag, "/pivot"}, got_pivot, exp_pivot);
        chk({tag, "/issues"}, 32'(issued.size()), 32'(exp_issues));
        for (int i = 0; i < issued.size() && i < exp_issues; i++)
            chk($sformatf("%s/addr%0d", tag, i), {15'd0, issued[i]}, 32'(row_addr(base, i)));
        @(negedge ap_clk);
        chk({tag, "/done_pulse"}, {31'd0, ap_done}, 32'd0);
        chk({tag, "/idle_after"}, {31'd0, ap_idle}, 32'd1);
        chk({tag, "/pivot_hold"}, pivot_row, exp_pivot);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "/idle"},  {31'd0, ap_idle},          32'd1);
        chk({tag, "/done"},  {31'd0, ap_done},          32'd0);
        chk({tag, "/ready"}, {31'd0, ap_ready},         32'd0);
        chk({tag, "/ce0"},   {31'd0, M_e_ce0},          32'd0);
        chk({tag, "/vld"},   {31'd0, pivot_row_ap_vld}, 32'd0);
        chk({tag, "/pivot"}, pivot_row,                 32'hFFFF_FFFF);
    endtask

    initial begin
        int seen;
        int n;

        ap_rst_n = 1'b0;
        repeat (3) @(negedge ap_clk);
        chk_reset_outputs("rst");
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        mem.delete();
        mem[7 + 2 * STRIDE] = 1;
        run_scan("t1_hit2", 5, 17'd7, 0);

        mem.delete();
        run_scan("t2_miss", 4, 17'd7, 0);

        run_scan("t3_zero", 0, 17'd50, 0);
        run_scan("t3_neg", -3, 17'd50, 0);

        mem.delete();
        mem[11] = 1;
        mem[11 + STRIDE] = 1;
        run_scan("t4_gnt", 3, 17'd11, 2);

        mem.delete();
        mem[32'h40] = 1;
        run_scan("t5_wrap", 2, 17'h1FF00, 0);

        // Abort a 10-row scan with reset in cycle 2
        mem.delete();
        mem[100 + 8 * STRIDE] = 1;
        row_count = 10;
        col_base  = 17'd100;
        ap_start  = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        mem_gnt  = 1'b1;
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        chk_reset_outputs("t6_abort");
        ap_rst_n = 1'b1;
        mem_gnt  = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge ap_clk);
            if (ap_done) seen++;
        end
        chk("t6_no_done", 32'(seen), 32'd0);
        run_scan("t6_restart", 10, 17'd100, 0);

        for (int it = 0; it < 10; it++) begin
            logic [ADDR_W-1:0] b;
            mem.delete();
            b = ADDR_W'($urandom());
            n = (it == 9) ? -int'($urandom_range(0, 5)) : int'($urandom_range(1, 14));
            for (int k = 0; k < 14; k++)
                mem[row_addr(b, k)] = ($urandom_range(0, 5) == 0) ? 32'd1 : ($urandom() | 32'h2);
            run_scan($sformatf("rnd%0d", it), n, b, (it % 3 == 0) ? 0 : 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
